// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard scheduler.
//   - Forwarding mux encodings used by the E-stage operand muxes.
//   - Multiply/divide sequencer state encoding.
//   - Small helpers for register-match and forward-select decoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // True when a producer writes a nonzero register read by either source.
    function automatic logic dst_match(input logic [4:0] dst,
                                       input logic [4:0] src_a,
                                       input logic [4:0] src_b);
        return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
    endfunction

    // M stage has priority since it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wr_m,
                                           input logic       rw_m,
                                           input logic [4:0] wr_w,
                                           input logic       rw_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0 && src == wr_m && rw_m) begin
            sel = FWD_MEM;
        end else if (src != 5'd0 && src == wr_w && rw_w) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Bundle between the datapath and the hazard scheduler.
//   master: the scheduler (reads pipeline register fields, drives controls).
//   slave : the datapath (drives register fields, consumes controls).
interface hazard_sched_if;
    logic [4:0] RsD, RtD, RsE, RtE;
    logic [4:0] WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic       MemtoRegE, MemtoRegM;
    logic       BranchD, PCSrcD;
    logic       MulDivD, HiLoReadD;
    logic       MulDivStartE, MulDivOpE;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       ForwardAD, ForwardBD;
    logic       MdBusy, MdDone;

    modport master (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MulDivD, HiLoReadD, MulDivStartE, MulDivOpE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MdBusy, MdDone
    );

    modport slave (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MulDivD, HiLoReadD, MulDivStartE, MulDivOpE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MdBusy, MdDone
    );
endinterface

// File: rtl/hazard_sched_muldiv_seq.sv
// Multiply/divide busy/done sequencer.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_start      : MD instruction in E starts the unit this cycle
//   i_op         : 0 = multiply, 1 = divide
//   o_busy       : unit computing
//   o_done       : one-cycle pulse, HI/LO written at end of this cycle
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    input  logic i_op,
    output logic o_busy,
    output logic o_done
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

    md_state_e       r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [CntW-1:0] w_load;

    assign w_load = i_op ? DivLoad : MulLoad;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            MD_IDLE: begin
                if (i_start) begin
                    w_cnt_nxt   = w_load;
                    w_state_nxt = MD_BUSY;
                end
            end
            // A start while busy cannot happen (dependent MD ops are stalled).
            MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = MD_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            MD_DONE: begin
                if (i_start) begin
                    w_cnt_nxt   = w_load;
                    w_state_nxt = MD_BUSY;
                end else begin
                    w_state_nxt = MD_IDLE;
                end
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_busy = (r_state == MD_BUSY);
    assign o_done = (r_state == MD_DONE);

endmodule

// File: rtl/hazard_sched.sv
// Central hazard controller of the 5-stage MIPS pipeline.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   hz           : hazard_sched_if.master -- pipeline register fields in,
//                  stall/flush/forward/MD status controls out
// All controls are forced low while reset_n is low.
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    hazard_sched_if.master hz
);

    logic       w_md_busy, w_md_done;
    logic       w_lwstall, w_brstall, w_mdstall, w_stall;
    logic [1:0] w_fwd_ae, w_fwd_be;
    logic       w_fwd_ad, w_fwd_bd;

    muldiv_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_muldiv_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (hz.MulDivStartE),
        .i_op    (hz.MulDivOpE),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done)
    );

    assign w_fwd_ae = fwd_sel(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    assign w_fwd_be = fwd_sel(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    assign w_fwd_ad = (hz.RsD != 5'd0) && (hz.RsD == hz.WriteRegM) && hz.RegWriteM;
    assign w_fwd_bd = (hz.RtD != 5'd0) && (hz.RtD == hz.WriteRegM) && hz.RegWriteM;

    assign w_lwstall = hz.MemtoRegE && dst_match(hz.WriteRegE, hz.RsD, hz.RtD);
    // Branches compare in D, so any ALU result still in E, or a load still in M, must wait.
    assign w_brstall = hz.BranchD &&
                       ((hz.RegWriteE && dst_match(hz.WriteRegE, hz.RsD, hz.RtD)) ||
                        (hz.MemtoRegM && dst_match(hz.WriteRegM, hz.RsD, hz.RtD)));
    // In DONE the HI/LO write lands before a reader in D reaches E, so no stall there.
    assign w_mdstall = (w_md_busy || hz.MulDivStartE) && (hz.HiLoReadD || hz.MulDivD);
    assign w_stall   = w_lwstall | w_brstall | w_mdstall;

    assign hz.StallF    = reset_n & w_stall;
    assign hz.StallD    = reset_n & w_stall;
    assign hz.FlushE    = reset_n & w_stall;
    // A stalled branch is re-evaluated next cycle, so the squash waits.
    assign hz.FlushD    = reset_n & hz.PCSrcD & ~w_stall;
    assign hz.ForwardAE = reset_n ? w_fwd_ae : FWD_RF;
    assign hz.ForwardBE = reset_n ? w_fwd_be : FWD_RF;
    assign hz.ForwardAD = reset_n & w_fwd_ad;
    assign hz.ForwardBD = reset_n & w_fwd_bd;
    assign hz.MdBusy    = reset_n & w_md_busy;
    assign hz.MdDone    = reset_n & w_md_done;

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_sched_if hz ();

    hazard_sched #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pcsrc_d, hilo_d, md_d;
        logic [9:0] exp;  // {StallF,StallD,FlushE,FlushD,FAE,FBE,FAD,FBD}
    } vec_t;

    localparam int NVec = 14;
    vec_t vecs [NVec];

    function automatic vec_t mk(input int rs_d, input int rt_d, input int rs_e, input int rt_e,
                                input int wr_e, input int wr_m, input int wr_w,
                                input int rw_e, input int rw_m, input int rw_w,
                                input int m2r_e, input int m2r_m, input int br_d,
                                input int pcsrc_d, input int hilo_d, input int md_d,
                                input logic [9:0] exp);
        vec_t v;
        v.rs_d = 5'(rs_d);  v.rt_d = 5'(rt_d);  v.rs_e = 5'(rs_e);  v.rt_e = 5'(rt_e);
        v.wr_e = 5'(wr_e);  v.wr_m = 5'(wr_m);  v.wr_w = 5'(wr_w);
        v.rw_e = 1'(rw_e);  v.rw_m = 1'(rw_m);  v.rw_w = 1'(rw_w);
        v.m2r_e = 1'(m2r_e); v.m2r_m = 1'(m2r_m); v.br_d = 1'(br_d);
        v.pcsrc_d = 1'(pcsrc_d); v.hilo_d = 1'(hilo_d); v.md_d = 1'(md_d);
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        hz.RsD = '0; hz.RtD = '0; hz.RsE = '0; hz.RtE = '0;
        hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0;
        hz.BranchD = 1'b0; hz.PCSrcD = 1'b0; hz.MulDivD = 1'b0; hz.HiLoReadD = 1'b0;
        hz.MulDivStartE = 1'b0; hz.MulDivOpE = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hz.RsD = v.rs_d; hz.RtD = v.rt_d; hz.RsE = v.rs_e; hz.RtE = v.rt_e;
        hz.WriteRegE = v.wr_e; hz.WriteRegM = v.wr_m; hz.WriteRegW = v.wr_w;
        hz.RegWriteE = v.rw_e; hz.RegWriteM = v.rw_m; hz.RegWriteW = v.rw_w;
        hz.MemtoRegE = v.m2r_e; hz.MemtoRegM = v.m2r_m;
        hz.BranchD = v.br_d; hz.PCSrcD = v.pcsrc_d;
        hz.HiLoReadD = v.hilo_d; hz.MulDivD = v.md_d;
        hz.MulDivStartE = 1'b0; hz.MulDivOpE = 1'b0;
    endtask

    function automatic logic [9:0] ctl();
        return {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD,
                hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD};
    endfunction

    // Next cycle: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // An MD start while the unit is busy is a protocol violation.
    always @(negedge clk) begin
        if (reset_n && hz.MdBusy && hz.MulDivStartE) begin
            errors++;
            $display("FAIL md_start_while_busy: start=1 busy=1 expected no start at %0t", $time);
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        clear_inputs();

        vecs[0]  = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 10'b0000_00_00_00);
        vecs[1]  = mk(0,0,5,0, 0,5,5, 0,1,1, 0,0,0,0,0,0, 10'b0000_10_00_00);
        vecs[2]  = mk(0,0,0,0, 0,5,5, 0,1,1, 0,0,0,0,0,0, 10'b0000_00_00_00);
        vecs[3]  = mk(0,0,7,7, 0,0,7, 0,0,1, 0,0,0,0,0,0, 10'b0000_01_01_00);
        vecs[4]  = mk(0,0,0,9, 0,9,9, 0,0,1, 0,0,0,0,0,0, 10'b0000_00_01_00);
        vecs[5]  = mk(0,8,0,0, 8,0,0, 1,0,0, 1,0,0,0,0,0, 10'b1110_00_00_00);
        vecs[6]  = mk(0,0,0,0, 0,0,0, 1,0,0, 1,0,0,0,0,0, 10'b0000_00_00_00);
        vecs[7]  = mk(3,0,0,0, 3,0,0, 1,0,0, 0,0,1,1,0,0, 10'b1110_00_00_00);
        vecs[8]  = mk(3,0,0,0, 0,3,0, 0,1,0, 0,0,1,1,0,0, 10'b0001_00_00_10);
        vecs[9]  = mk(0,4,0,0, 0,4,0, 0,1,0, 0,1,1,0,0,0, 10'b1110_00_00_01);
        vecs[10] = mk(3,0,0,0, 3,0,0, 1,0,0, 0,0,0,0,0,0, 10'b0000_00_00_00);
        vecs[11] = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,1,0,0, 10'b0001_00_00_00);
        vecs[12] = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,1,1, 10'b0000_00_00_00);
        vecs[13] = mk(0,0,6,6, 0,6,0, 0,1,0, 0,0,0,0,0,0, 10'b0000_10_10_00);

        // Reset: outputs forced low even with hazard-producing inputs.
        apply(vecs[5]);
        #12;
        check("reset_ctl", 32'(ctl()), 32'd0);
        check("reset_md", {30'd0, hz.MdBusy, hz.MdDone}, 32'd0);
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        check("post_reset_md", {30'd0, hz.MdBusy, hz.MdDone}, 32'd0);

        // Combinational vector table.
        for (int i = 0; i < NVec; i++) begin
            apply(vecs[i]);
            #2;
            check($sformatf("vec%0d", i), 32'(ctl()), 32'(vecs[i].exp));
        end
        clear_inputs();

        // Load-use: one stall cycle, then W forwarding to the consumer in E.
        next_cycle();
        hz.WriteRegE = 5'd8; hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.RtD = 5'd8;
        #2 check("lw_stall_c0", {29'd0, hz.StallF, hz.StallD, hz.FlushE}, 32'b111);
        next_cycle();
        hz.WriteRegE = 5'd0; hz.MemtoRegE = 1'b0; hz.RegWriteE = 1'b0;
        hz.WriteRegM = 5'd8; hz.MemtoRegM = 1'b1; hz.RegWriteM = 1'b1;
        #2 check("lw_stall_c1", {29'd0, hz.StallF, hz.StallD, hz.FlushE}, 32'b000);
        next_cycle();
        hz.RtD = 5'd0; hz.RtE = 5'd8;
        hz.WriteRegM = 5'd0; hz.MemtoRegM = 1'b0; hz.RegWriteM = 1'b0;
        hz.WriteRegW = 5'd8; hz.RegWriteW = 1'b1;
        #2 check("lw_fwd_be", {30'd0, hz.ForwardBE}, 32'b01);
        clear_inputs();

        // Branch: stall while producer in E, then forward from M and squash.
        next_cycle();
        hz.BranchD = 1'b1; hz.RsD = 5'd3; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd3;
        #2 check("br_stall", {31'd0, hz.StallD}, 32'd1);
        next_cycle();
        hz.RegWriteE = 1'b0; hz.WriteRegE = 5'd0;
        hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd3; hz.PCSrcD = 1'b1;
        #2 check("br_fwd", {29'd0, hz.ForwardAD, hz.StallD, hz.FlushD}, 32'b101);
        clear_inputs();

        // Multiply followed by a held HI/LO reader.
        next_cycle();
        hz.MulDivStartE = 1'b1; hz.MulDivOpE = 1'b0; hz.HiLoReadD = 1'b1;
        #2 check("mul_c0", {29'd0, hz.MdBusy, hz.MdDone, hz.StallD}, 32'b001);
        next_cycle();
        hz.MulDivStartE = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #2 check($sformatf("mul_c%0d", c), {29'd0, hz.MdBusy, hz.MdDone, hz.StallD}, 32'b101);
            next_cycle();
        end
        #2 check("mul_c5", {29'd0, hz.MdBusy, hz.MdDone, hz.StallD}, 32'b010);
        next_cycle();
        #2 check("mul_c6", {29'd0, hz.MdBusy, hz.MdDone, hz.StallD}, 32'b000);
        clear_inputs();

        // Divide, then a multiply started in the DONE cycle.
        next_cycle();
        hz.MulDivStartE = 1'b1; hz.MulDivOpE = 1'b1;
        next_cycle();
        hz.MulDivStartE = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            #2 check($sformatf("div_busy_c%0d", c), {30'd0, hz.MdBusy, hz.MdDone}, 32'b10);
            next_cycle();
        end
        hz.MulDivStartE = 1'b1; hz.MulDivOpE = 1'b0;
        #2 check("div_done_c33", {30'd0, hz.MdBusy, hz.MdDone}, 32'b01);
        next_cycle();
        hz.MulDivStartE = 1'b0;
        for (int c = 34; c <= 37; c++) begin
            #2 check($sformatf("b2b_busy_c%0d", c), {30'd0, hz.MdBusy, hz.MdDone}, 32'b10);
            next_cycle();
        end
        #2 check("b2b_done_c38", {30'd0, hz.MdBusy, hz.MdDone}, 32'b01);
        next_cycle();

        // Asynchronous reset during a divide aborts it.
        next_cycle();
        hz.MulDivStartE = 1'b1; hz.MulDivOpE = 1'b1;
        next_cycle();
        hz.MulDivStartE = 1'b0;
        hz.RsE = 5'd5; hz.WriteRegM = 5'd5; hz.RegWriteM = 1'b1; hz.HiLoReadD = 1'b1;
        for (int c = 1; c < 10; c++) next_cycle();
        #2 check("rst_pre", {28'd0, hz.MdBusy, hz.StallD, hz.ForwardAE}, 32'b1110);
        reset_n = 1'b0;
        #1 check("rst_async_ctl", 32'(ctl()), 32'd0);
        check("rst_async_md", {30'd0, hz.MdBusy, hz.MdDone}, 32'd0);
        clear_inputs();
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #2 check($sformatf("rst_idle_c%0d", c), {30'd0, hz.MdBusy, hz.MdDone}, 32'b00);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
